// File: rtl/goal_score_pkg.sv
// Shared types and constants for the goal score keeper: match states, winner codes, score width.
package goal_score_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_HOLD      = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

// File: rtl/frame_event_latch.sv
// Sticky per-frame collision latch: set on any hit, reloaded with the same-cycle hit on
// startOfFrame so that hit lands in the next frame; force clear overrides both.
module frame_event_latch (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    input  logic start_of_frame,
    input  logic force_clr,
    output logic hit_latched
);

    logic hit_q;
    logic hit_d;

    always_comb begin
        hit_d = hit_q | hit;
        if (force_clr) begin
            hit_d = 1'b0;
        end else if (start_of_frame) begin
            hit_d = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_latched = hit_q;

endmodule

// File: rtl/goal_score_keeper.sv
// Match FSM and score registers fed by per-frame goal latches.
// Optional GOAL_FLASH_EN adds a goal_flash output that blinks every 8 frames during HOLD.
//
// state        | meaning
// ST_IDLE      | after reset, waiting for newGame
// ST_PLAY      | collisions counted at each startOfFrame
// ST_HOLD      | post-goal, HOLD_FRAMES frames of collisions ignored
// ST_GAME_OVER | a player reached WIN_SCORE, everything frozen until newGame
module goal_score_keeper
    import goal_score_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               goal_p1_hit,
    input  logic               goal_p2_hit,
    input  logic               newGame,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               ball_reset,
    output logic               game_over,
    output logic [1:0]         winner
`ifdef GOAL_FLASH_EN
    ,output logic              goal_flash
`endif
);

    localparam logic [SCORE_W-1:0] WIN_C  = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         HOLD_C = 8'(HOLD_FRAMES);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic [1:0]         winner_q, winner_d;
    logic               ball_reset_q, ball_reset_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic               hit1, hit2;
    logic               latch_clr;

    // Latches only accumulate while playing; every other state discards collisions.
    assign latch_clr = newGame | (state_q != ST_PLAY);

    frame_event_latch u_latch_p1 (
        .clk            (clk),
        .reset          (reset),
        .hit            (goal_p1_hit),
        .start_of_frame (startOfFrame),
        .force_clr      (latch_clr),
        .hit_latched    (hit1)
    );

    frame_event_latch u_latch_p2 (
        .clk            (clk),
        .reset          (reset),
        .hit            (goal_p2_hit),
        .start_of_frame (startOfFrame),
        .force_clr      (latch_clr),
        .hit_latched    (hit2)
    );

    always_comb begin
        state_d      = state_q;
        score_p1_d   = score_p1_q;
        score_p2_d   = score_p2_q;
        winner_d     = winner_q;
        hold_cnt_d   = hold_cnt_q;
        ball_reset_d = 1'b0;
        if (newGame) begin
            state_d      = ST_PLAY;
            score_p1_d   = '0;
            score_p2_d   = '0;
            winner_d     = WIN_NONE;
            ball_reset_d = 1'b1;
        end else if (startOfFrame) begin
            case (state_q)
                ST_PLAY: begin
                    // Both goals in one frame is ambiguous and credits nobody.
                    if (hit1 && !hit2 && score_p1_q < WIN_C) begin
                        score_p1_d = score_p1_q + 1'b1;
                        if (score_p1_d == WIN_C) begin
                            state_d  = ST_GAME_OVER;
                            winner_d = WIN_P1;
                        end else begin
                            state_d      = ST_HOLD;
                            hold_cnt_d   = HOLD_C;
                            ball_reset_d = 1'b1;
                        end
                    end else if (hit2 && !hit1 && score_p2_q < WIN_C) begin
                        score_p2_d = score_p2_q + 1'b1;
                        if (score_p2_d == WIN_C) begin
                            state_d  = ST_GAME_OVER;
                            winner_d = WIN_P2;
                        end else begin
                            state_d      = ST_HOLD;
                            hold_cnt_d   = HOLD_C;
                            ball_reset_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                    if (hold_cnt_q <= 8'd1) begin
                        hold_cnt_d = '0;
                        state_d    = ST_PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            score_p1_q   <= '0;
            score_p2_q   <= '0;
            winner_q     <= WIN_NONE;
            hold_cnt_q   <= '0;
            ball_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            winner_q     <= winner_d;
            hold_cnt_q   <= hold_cnt_d;
            ball_reset_q <= ball_reset_d;
        end
    end

`ifdef GOAL_FLASH_EN
    logic [2:0] flash_cnt_q, flash_cnt_d;
    logic       goal_flash_q, goal_flash_d;

    always_comb begin
        flash_cnt_d  = flash_cnt_q;
        goal_flash_d = goal_flash_q;
        if (state_q != ST_HOLD || state_d != ST_HOLD) begin
            flash_cnt_d  = '0;
            goal_flash_d = 1'b0;
        end else if (startOfFrame) begin
            flash_cnt_d = flash_cnt_q + 1'b1;
            if (flash_cnt_q == 3'd7) begin
                goal_flash_d = ~goal_flash_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_cnt_q  <= '0;
            goal_flash_q <= 1'b0;
        end else begin
            flash_cnt_q  <= flash_cnt_d;
            goal_flash_q <= goal_flash_d;
        end
    end

    assign goal_flash = goal_flash_q;
`endif

    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign winner     = winner_q;
    assign ball_reset = ball_reset_q;
    assign game_over  = (state_q == ST_GAME_OVER);

endmodule
